ifu: RTL and testbench

//  Instruction fetch unit: the front-end producer feeding the id stage.
//  - Owns the PC and issues in-order word fetches on a pipelined req/gnt/rvalid instruction-memory port.
//  - Buffers returned words with their PCs and hands {pc, inst} to id through a valid/ready handshake.
//  - Takes redirects (branch_i / branch_pc_i) from id and flushes everything fetched down the wrong path.

---
 rtl/ifu_pkg.sv | 16 +
 rtl/ifu_fetch_queue.sv | 102 ++++++++++
 rtl/ifu.sv | 102 ++++++++++
 tb/tb_ifu.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: default geometry,
// the NOP presented when no instruction is valid, and pointer sizing.
package ifu_pkg;

  localparam int          DEF_INST_ADDR_W = 32;
  localparam int          DEF_INST_W      = 32;
  localparam int          DEF_FQ_DEPTH    = 2;
  localparam logic [31:0] DEF_RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] DEF_INST_NOP    = 32'h0000_0013;

  // Pointer width for a power-of-2 ring: one extra bit tells full from empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ifu_fetch_queue.sv
// Fetch queue: in-order ring of {pc, inst, filled} entries with three
// pointers. alloc reserves a slot at grant time, fill writes returned data in
// request order, pop releases the head. flush empties the ring in one edge.
module ifu_fetch_queue
  import ifu_pkg::*;
#(
  parameter int              DEPTH    = DEF_FQ_DEPTH,
  parameter int              AW       = DEF_INST_ADDR_W,
  parameter int              IW       = DEF_INST_W,
  parameter logic [AW-1:0]   RESET_PC = AW'(DEF_RESET_PC),
  localparam int             PW       = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          alloc,
  input  logic [AW-1:0] alloc_pc,
  input  logic          fill,
  input  logic [IW-1:0] fill_inst,
  input  logic          pop,
  output logic          head_valid,
  output logic [AW-1:0] head_pc,
  output logic [IW-1:0] head_inst,
  output logic [PW-1:0] used,
  output logic [PW-1:0] pending
);

  localparam int IXW = PW - 1;

  logic [PW-1:0]  alloc_ptr_r;
  logic [PW-1:0]  fill_ptr_r;
  logic [PW-1:0]  head_ptr_r;
  logic [AW-1:0]  pc_r   [DEPTH];
  logic [IW-1:0]  inst_r [DEPTH];
  logic [DEPTH-1:0] filled_r;

  logic [IXW-1:0] alloc_idx_s;
  logic [IXW-1:0] fill_idx_s;
  logic [IXW-1:0] head_idx_s;

  assign alloc_idx_s = alloc_ptr_r[IXW-1:0];
  assign fill_idx_s  = fill_ptr_r[IXW-1:0];
  assign head_idx_s  = head_ptr_r[IXW-1:0];

  // Slots reserved (filled or waiting) and slots still waiting for data.
  assign used    = alloc_ptr_r - head_ptr_r;
  assign pending = alloc_ptr_r - fill_ptr_r;

  // Pointer advance; a flush returns all three pointers to slot 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alloc_ptr_r <= PW'(0);
      fill_ptr_r  <= PW'(0);
      head_ptr_r  <= PW'(0);
    end else if (flush) begin
      alloc_ptr_r <= PW'(0);
      fill_ptr_r  <= PW'(0);
      head_ptr_r  <= PW'(0);
    end else begin
      if (alloc) alloc_ptr_r <= alloc_ptr_r + PW'(1);
      if (fill)  fill_ptr_r  <= fill_ptr_r + PW'(1);
      if (pop)   head_ptr_r  <= head_ptr_r + PW'(1);
    end
  end

  // Per-slot filled flags: set by returned data, cleared by pop or flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filled_r <= '0;
    end else if (flush) begin
      filled_r <= '0;
    end else begin
      if (fill) filled_r[fill_idx_s] <= 1'b1;
      if (pop)  filled_r[head_idx_s] <= 1'b0;
    end
  end

  // Slot payload: PC captured at grant, instruction captured at return.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_r[i]   <= RESET_PC;
        inst_r[i] <= IW'(DEF_INST_NOP);
      end
    end else begin
      if (alloc) pc_r[alloc_idx_s]  <= alloc_pc;
      if (fill)  inst_r[fill_idx_s] <= fill_inst;
    end
  end

  // Head presentation straight from slot registers; NOP when the head is empty.
  always_comb begin
    head_valid = filled_r[head_idx_s];
    head_pc    = pc_r[head_idx_s];
    if (head_valid) begin
      head_inst = inst_r[head_idx_s];
    end else begin
      head_inst = IW'(DEF_INST_NOP);
    end
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, issues in-order word fetches on a
// req/gnt/rvalid port, buffers returns in the fetch queue and presents
// {pc, inst} to id. A redirect flushes the queue and counts the fetches
// already in flight so their responses can be dropped on arrival.
module ifu
  import ifu_pkg::*;
#(
  parameter int                      INST_ADDR_W = DEF_INST_ADDR_W,
  parameter int                      INST_W      = DEF_INST_W,
  parameter int                      FQ_DEPTH    = DEF_FQ_DEPTH,
  parameter logic [INST_ADDR_W-1:0]  RESET_PC    = INST_ADDR_W'(DEF_RESET_PC)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   branch_i,
  input  logic [INST_ADDR_W-1:0] branch_pc_i,
  input  logic                   id_ready_i,
  output logic                   inst_valid_o,
  output logic [INST_ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0]      inst_o,
  output logic                   imem_req_o,
  output logic [INST_ADDR_W-1:0] imem_addr_o,
  input  logic                   imem_gnt_i,
  input  logic                   imem_rvalid_i,
  input  logic [INST_W-1:0]      imem_rdata_i
);

  localparam int PW = ptr_w(FQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [INST_ADDR_W-1:0] WORD_MASK = {{(INST_ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [INST_ADDR_W-1:0] PC_STEP   = INST_ADDR_W'(4);

  logic [INST_ADDR_W-1:0] pc_r;
  logic [PW-1:0]          discard_r;
  logic [PW-1:0]          used_s;
  logic [PW-1:0]          pending_s;
  logic [CW-1:0]          inflight_s;
  logic                   pop_s;
  logic                   grant_s;
  logic                   fill_s;
  logic                   credit_ok_s;

  assign pop_s = inst_valid_o & id_ready_i;

  // Everything that still holds a slot or a memory response after this
  // cycle's pop: queued entries plus stale fetches awaiting their drop.
  assign inflight_s  = CW'(used_s) + CW'(discard_r) - CW'(pop_s);
  assign credit_ok_s = (inflight_s < CW'(FQ_DEPTH));

  // A redirect cycle never takes a grant so the new target starts clean.
  assign imem_req_o  = ~rst & credit_ok_s & ~branch_i;
  assign imem_addr_o = pc_r;
  assign grant_s     = imem_req_o & imem_gnt_i;

  // Responses owed to the wrong path are consumed before any real data.
  assign fill_s = imem_rvalid_i & (discard_r == PW'(0)) & ~branch_i;

  // Fetch PC: redirect target (word aligned) or +4 per granted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r <= RESET_PC;
    end else if (branch_i) begin
      pc_r <= branch_pc_i & WORD_MASK;
    end else if (grant_s) begin
      pc_r <= pc_r + PC_STEP;
    end
  end

  // Stale-response counter: reloaded on redirect with every granted but
  // unreturned fetch (less one arriving now), then counted down per rvalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      discard_r <= PW'(0);
    end else if (branch_i) begin
      discard_r <= discard_r + pending_s - PW'(imem_rvalid_i);
    end else if (imem_rvalid_i && (discard_r != PW'(0))) begin
      discard_r <= discard_r - PW'(1);
    end
  end

  ifu_fetch_queue #(
    .DEPTH    (FQ_DEPTH),
    .AW       (INST_ADDR_W),
    .IW       (INST_W),
    .RESET_PC (RESET_PC)
  ) u_fetch_queue (
    .clk        (clk),
    .rst        (rst),
    .flush      (branch_i),
    .alloc      (grant_s),
    .alloc_pc   (pc_r),
    .fill       (fill_s),
    .fill_inst  (imem_rdata_i),
    .pop        (pop_s),
    .head_valid (inst_valid_o),
    .head_pc    (pc_o),
    .head_inst  (inst_o),
    .used       (used_s),
    .pending    (pending_s)
  );

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: directed scenarios plus a randomized run against a
// transaction-level model (list of outstanding fetches and list of returned
// instructions awaiting id). A second instance checks PC wrap from a high
// reset PC.
module tb_ifu;

  localparam int          FQ_DEPTH = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk, rst, rst2;
  logic        branch_i, id_ready_i, imem_gnt_i, imem_rvalid_i;
  logic [31:0] branch_pc_i, imem_rdata_i;
  logic        inst_valid_o, imem_req_o;
  logic [31:0] pc_o, inst_o, imem_addr_o;

  logic        br2, rdy2, gnt2, rv2;
  logic [31:0] bpc2, rd2;
  logic        v2, req2;
  logic [31:0] pc2, inst2, addr2;

  ifu #(.INST_ADDR_W(32), .INST_W(32), .FQ_DEPTH(FQ_DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .branch_i(branch_i), .branch_pc_i(branch_pc_i),
    .id_ready_i(id_ready_i), .inst_valid_o(inst_valid_o), .pc_o(pc_o), .inst_o(inst_o),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i)
  );

  ifu #(.INST_ADDR_W(32), .INST_W(32), .FQ_DEPTH(FQ_DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst2), .branch_i(br2), .branch_pc_i(bpc2),
    .id_ready_i(rdy2), .inst_valid_o(v2), .pc_o(pc2), .inst_o(inst2),
    .imem_req_o(req2), .imem_addr_o(addr2), .imem_gnt_i(gnt2),
    .imem_rvalid_i(rv2), .imem_rdata_i(rd2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    int          due;
    bit          live;
  } tok_t;

  tok_t        toks[$];
  logic [31:0] rdq[$];
  logic [31:0] exp_pc;
  int          cyc, lat_min, lat_max;
  int          total, bad, dut_pops;
  logic        obs_pop, obs_req;
  logic [31:0] obs_pc, obs_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after negedge, check, update model, advance.
  task automatic step(input logic b, input logic [31:0] bpc, input logic rdy, input logic g);
    logic rv, ev, er;
    int   occ, d;
    tok_t t;
    rv = (toks.size() > 0) && (toks[0].due == cyc);
    imem_rvalid_i = rv;
    imem_rdata_i  = rv ? mem_word(toks[0].addr) : $urandom;
    branch_i      = b;
    branch_pc_i   = bpc;
    id_ready_i    = rdy;
    imem_gnt_i    = g;
    #1;
    ev = (rdq.size() > 0);
    chk("valid", 32'(inst_valid_o), 32'(ev));
    if (ev) begin
      chk("pc", pc_o, rdq[0]);
      chk("inst", inst_o, mem_word(rdq[0]));
    end else begin
      chk("nop", inst_o, NOP);
    end
    occ = toks.size() + rdq.size() - ((ev && rdy) ? 1 : 0);
    er  = !b && (occ < FQ_DEPTH);
    chk("req", 32'(imem_req_o), 32'(er));
    if (er && imem_req_o) chk("addr", imem_addr_o, exp_pc);
    chk("outstanding_le_depth", 32'(toks.size() <= FQ_DEPTH), 32'd1);
    obs_pop  = inst_valid_o & id_ready_i;
    obs_pc   = pc_o;
    obs_req  = imem_req_o;
    obs_addr = imem_addr_o;
    if (obs_pop) dut_pops++;
    if (ev && rdy) void'(rdq.pop_front());
    if (rv) begin
      t = toks.pop_front();
      if (t.live && !b) rdq.push_back(t.pc);
    end
    if (imem_req_o && g) begin
      d = cyc + int'($urandom_range(lat_max, lat_min));
      if (toks.size() > 0 && d <= toks[toks.size()-1].due) d = toks[toks.size()-1].due + 1;
      t.pc = exp_pc; t.addr = imem_addr_o; t.due = d; t.live = 1'b1;
      toks.push_back(t);
      exp_pc = exp_pc + 32'd4;
    end
    if (b) begin
      rdq.delete();
      foreach (toks[i]) toks[i].live = 1'b0;
      exp_pc = bpc & 32'hFFFF_FFFC;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [31:0] a0, first_req_addr, first_pop_pc, pa;
    logic        seen_req, seen_pop, pg;
    logic [31:0] exp5 [5];
    clk = 1'b0; rst = 1'b1; rst2 = 1'b1;
    branch_i = 1'b0; branch_pc_i = 32'h0; id_ready_i = 1'b0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    br2 = 1'b0; bpc2 = 32'h0; rdy2 = 1'b0; gnt2 = 1'b0; rv2 = 1'b0; rd2 = 32'h0;
    cyc = 0; exp_pc = 32'h0; lat_min = 1; lat_max = 1;
    total = 0; bad = 0; dut_pops = 0;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(inst_valid_o), 32'd0);
    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_inst", inst_o, NOP);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst2_pc", pc2, 32'hFFFF_FFF8);
    chk("rst2_req", 32'(req2), 32'd0);
    rst = 1'b0;

    // 1: streaming with 1-cycle memory; valid from cycle 2, one per cycle
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("t1_pops", 32'(dut_pops), 32'd8);

    // 2: id stalls for 5 cycles, then resumes
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("t2_req_dropped", 32'(obs_req), 32'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

    // 3: redirect with two fetches in flight
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 10; i++) begin
      if (toks.size() == 2) break;
      step(1'b0, 32'h0, 1'b1, 1'b1);
    end
    chk("t3_inflight", 32'(toks.size()), 32'd2);
    step(1'b1, 32'h0000_0102, 1'b1, 1'b1);
    seen_req = 1'b0; seen_pop = 1'b0; first_req_addr = 32'h0; first_pop_pc = 32'h0;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b1);
      if (obs_req && !seen_req) begin seen_req = 1'b1; first_req_addr = obs_addr; end
      if (obs_pop) begin seen_pop = 1'b1; first_pop_pc = obs_pc; break; end
    end
    chk("t3_seen_pop", 32'(seen_pop), 32'd1);
    chk("t3_first_req", first_req_addr, 32'h0000_0100);
    chk("t3_first_pc", first_pop_pc, 32'h0000_0100);

    // 4: grant withheld for 3 cycles with req high
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    a0 = obs_addr;
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t4_addr_stable", obs_addr, a0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

    // 6: random latency, grant, ready and redirects
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(99, 0) < 8), $urandom, ($urandom_range(99, 0) < 70),
           ($urandom_range(99, 0) < 75));
    end

    // Reset mid-operation clears everything at once
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(inst_valid_o), 32'd0);
    chk("midrst_req", 32'(imem_req_o), 32'd0);
    chk("midrst_inst", inst_o, NOP);
    chk("midrst_pc", pc_o, 32'h0);

    // 5: high reset PC wraps through zero
    exp5[0] = 32'hFFFF_FFF8; exp5[1] = 32'hFFFF_FFFC; exp5[2] = 32'h0000_0000;
    exp5[3] = 32'h0000_0004; exp5[4] = 32'h0000_0008;
    @(negedge clk);
    rst2 = 1'b0;
    pg = 1'b0; pa = 32'h0;
    for (int i = 0; i < 5; i++) begin
      rv2 = pg; rd2 = mem_word(pa); gnt2 = 1'b1; rdy2 = 1'b1;
      #1;
      chk("t5_req", 32'(req2), 32'd1);
      chk("t5_addr", addr2, exp5[i]);
      if (i >= 2) begin
        chk("t5_valid", 32'(v2), 32'd1);
        chk("t5_pc", pc2, exp5[i-2]);
        chk("t5_inst", inst2, mem_word(exp5[i-2]));
      end
      pg = req2 & gnt2; pa = addr2;
      @(posedge clk);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
